// File: rtl/mem_arbiter_if.sv
// Bundled request, response and shared-memory signals of the fetch/data arbiter.
// The master modport is the arbiter's view and the slave modport is the environment's view.
interface mem_arbiter_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 i_req;
  logic [BUS_WIDTH-1:0] i_addr;
  logic                 i_ack;
  logic [BUS_WIDTH-1:0] i_rdata;

  logic                 d_req;
  logic                 d_wr;
  logic [BUS_WIDTH-1:0] d_addr;
  logic [BUS_WIDTH-1:0] d_wdata;
  logic [1:0]           d_size;
  logic                 d_sz_ex;
  logic                 d_ack;
  logic [BUS_WIDTH-1:0] d_rdata;
  logic                 d_fault;

  logic                 mem_wr_en;
  logic [BUS_WIDTH-1:0] mem_addr;
  logic [BUS_WIDTH-1:0] mem_wdata;
  logic [1:0]           mem_size;
  logic                 mem_sz_ex;
  logic [BUS_WIDTH-1:0] mem_rdata;

  logic                 busy;

  modport master (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, d_size, d_sz_ex, mem_rdata,
    output i_ack, i_rdata, d_ack, d_rdata, d_fault,
           mem_wr_en, mem_addr, mem_wdata, mem_size, mem_sz_ex, busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, d_size, d_sz_ex, mem_rdata,
    input  i_ack, i_rdata, d_ack, d_rdata, d_fault,
           mem_wr_en, mem_addr, mem_wdata, mem_size, mem_sz_ex, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Each access takes IDLE -> ACCESS -> RESP, and all outputs come straight from flops.
module mem_arbiter #(
  parameter int BUS_WIDTH  = 32,
  parameter int I_MEM_SIZE = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam logic [BUS_WIDTH-1:0] I_MEM_LIMIT = BUS_WIDTH'(I_MEM_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t               state_r,     state_s;
  logic [BUS_WIDTH-1:0] lat_addr_r,  lat_addr_s;
  logic [BUS_WIDTH-1:0] lat_wdata_r, lat_wdata_s;
  logic [1:0]           lat_size_r,  lat_size_s;
  logic                 lat_sz_ex_r, lat_sz_ex_s;
  logic                 lat_wr_r,    lat_wr_s;
  logic                 gnt_d_r,     gnt_d_s;
  logic                 last_d_r,    last_d_s;
  logic [BUS_WIDTH-1:0] rd_r,        rd_s;
  logic                 i_ack_r,     i_ack_s;
  logic                 d_ack_r,     d_ack_s;
  logic                 fault_r,     fault_s;
  logic                 wr_en_r,     wr_en_s;
  logic                 busy_r,      busy_s;
  logic                 pick_d_s;

  // Data wins when it is the only requester, or on a tie when fetch was served last.
  assign pick_d_s = bus.d_req & (~bus.i_req | ~last_d_r);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_s     = state_r;
    lat_addr_s  = lat_addr_r;
    lat_wdata_s = lat_wdata_r;
    lat_size_s  = lat_size_r;
    lat_sz_ex_s = lat_sz_ex_r;
    lat_wr_s    = lat_wr_r;
    gnt_d_s     = gnt_d_r;
    last_d_s    = last_d_r;
    rd_s        = rd_r;
    i_ack_s     = 1'b0;
    d_ack_s     = 1'b0;
    fault_s     = 1'b0;
    wr_en_s     = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_req | bus.d_req) begin
          state_s = ST_ACCESS;
          busy_s  = 1'b1;
          gnt_d_s = pick_d_s;
          if (pick_d_s) begin
            lat_addr_s  = bus.d_addr;
            lat_wdata_s = bus.d_wdata;
            lat_size_s  = bus.d_size;
            lat_sz_ex_s = bus.d_sz_ex;
            lat_wr_s    = bus.d_wr;
            wr_en_s     = bus.d_wr & (bus.d_addr >= I_MEM_LIMIT);
          end else begin
            lat_addr_s  = bus.i_addr;
            lat_wdata_s = {BUS_WIDTH{1'b0}};
            lat_size_s  = 2'b10;
            lat_sz_ex_s = 1'b0;
            lat_wr_s    = 1'b0;
            wr_en_s     = 1'b0;
          end
        end else begin
          state_s = ST_IDLE;
          busy_s  = 1'b0;
        end
      end
      ST_ACCESS: begin
        state_s = ST_RESP;
        busy_s  = 1'b1;
        rd_s    = bus.mem_rdata;
        i_ack_s = ~gnt_d_r;
        d_ack_s = gnt_d_r;
        fault_s = gnt_d_r & lat_wr_r & (lat_addr_r < I_MEM_LIMIT);
      end
      ST_RESP: begin
        // Clearing the latches here is what returns the memory port to zero in IDLE.
        state_s     = ST_IDLE;
        busy_s      = 1'b0;
        last_d_s    = gnt_d_r;
        lat_addr_s  = {BUS_WIDTH{1'b0}};
        lat_wdata_s = {BUS_WIDTH{1'b0}};
        lat_size_s  = 2'b00;
        lat_sz_ex_s = 1'b0;
        lat_wr_s    = 1'b0;
      end
      default: begin
        state_s     = ST_IDLE;
        busy_s      = 1'b0;
        lat_addr_s  = {BUS_WIDTH{1'b0}};
        lat_wdata_s = {BUS_WIDTH{1'b0}};
        lat_size_s  = 2'b00;
        lat_sz_ex_s = 1'b0;
        lat_wr_s    = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; the reset clears them, including a write strobe in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_addr_r  <= {BUS_WIDTH{1'b0}};
      lat_wdata_r <= {BUS_WIDTH{1'b0}};
      lat_size_r  <= 2'b00;
      lat_sz_ex_r <= 1'b0;
      lat_wr_r    <= 1'b0;
      gnt_d_r     <= 1'b0;
      last_d_r    <= 1'b1;
      rd_r        <= {BUS_WIDTH{1'b0}};
      i_ack_r     <= 1'b0;
      d_ack_r     <= 1'b0;
      fault_r     <= 1'b0;
      wr_en_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      lat_addr_r  <= lat_addr_s;
      lat_wdata_r <= lat_wdata_s;
      lat_size_r  <= lat_size_s;
      lat_sz_ex_r <= lat_sz_ex_s;
      lat_wr_r    <= lat_wr_s;
      gnt_d_r     <= gnt_d_s;
      last_d_r    <= last_d_s;
      rd_r        <= rd_s;
      i_ack_r     <= i_ack_s;
      d_ack_r     <= d_ack_s;
      fault_r     <= fault_s;
      wr_en_r     <= wr_en_s;
      busy_r      <= busy_s;
    end
  end

  assign bus.i_ack     = i_ack_r;
  assign bus.i_rdata   = rd_r;
  assign bus.d_ack     = d_ack_r;
  assign bus.d_rdata   = rd_r;
  assign bus.d_fault   = fault_r;
  assign bus.mem_wr_en = wr_en_r;
  assign bus.mem_addr  = lat_addr_r;
  assign bus.mem_wdata = lat_wdata_r;
  assign bus.mem_size  = lat_size_r;
  assign bus.mem_sz_ex = lat_sz_ex_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, stores, the protected region edge, tie alternation,
// and a reset that arrives in the middle of a store.
module tb_mem_arbiter;
  localparam int BW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  mem_arbiter_if #(.BUS_WIDTH(BW)) bus();

  mem_arbiter #(.BUS_WIDTH(BW), .I_MEM_SIZE(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h0000_0008) ? 32'h0050_0093 : a + 32'h1000_0000;
  endfunction

  assign bus.mem_rdata = mem_model(bus.mem_addr);

  // Write-strobe monitor sampled on the falling edge.
  int          wr_cnt    = 0;
  logic [31:0] wr_addr_q = 32'h0;
  logic [31:0] wr_data_q = 32'h0;
  always @(negedge clk) begin
    if (bus.mem_wr_en === 1'b1) begin
      wr_cnt    <= wr_cnt + 1;
      wr_addr_q <= bus.mem_addr;
      wr_data_q <= bus.mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(output int n, output logic got_d);
    n     = 0;
    got_d = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1) begin
        n     = k;
        got_d = bus.d_ack;
        break;
      end
    end
    if (n == 0) check_eq("ack_timeout", 32'd0, 32'd1);
  endtask

  // One data access from IDLE; checks the ACCESS cycle, the response and the write count.
  task automatic run_d(input string tag, input logic [31:0] addr, input logic wr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic sz_ex,
                       input logic exp_wr, input logic exp_fault, input logic [31:0] exp_rd);
    int   w0;
    int   n;
    logic gd;
    w0          = wr_cnt;
    bus.d_addr  = addr;
    bus.d_wr    = wr;
    bus.d_wdata = wdata;
    bus.d_size  = size;
    bus.d_sz_ex = sz_ex;
    bus.d_req   = 1'b1;
    @(negedge clk);
    check_eq({tag, "_acc_wr_en"}, 32'(bus.mem_wr_en), 32'(exp_wr));
    check_eq({tag, "_acc_addr"}, bus.mem_addr, addr);
    check_eq({tag, "_acc_size"}, 32'(bus.mem_size), 32'(size));
    check_eq({tag, "_acc_sz_ex"}, 32'(bus.mem_sz_ex), 32'(sz_ex));
    wait_ack(n, gd);
    bus.d_req = 1'b0;
    check_eq({tag, "_lat"}, 32'(n), 32'd1);
    check_eq({tag, "_d_ack"}, 32'(gd), 32'd1);
    check_eq({tag, "_i_ack"}, 32'(bus.i_ack), 32'd0);
    check_eq({tag, "_fault"}, 32'(bus.d_fault), 32'(exp_fault));
    check_eq({tag, "_wr_en_resp"}, 32'(bus.mem_wr_en), 32'd0);
    if (!wr) check_eq({tag, "_rdata"}, bus.d_rdata, exp_rd);
    @(negedge clk);
    check_eq({tag, "_ack_drop"}, 32'(bus.d_ack), 32'd0);
    check_eq({tag, "_idle_addr"}, bus.mem_addr, 32'h0);
    check_eq({tag, "_wr_cnt"}, 32'(wr_cnt - w0), 32'(exp_wr));
    if (exp_wr) begin
      check_eq({tag, "_wr_addr"}, wr_addr_q, addr);
      check_eq({tag, "_wr_data"}, wr_data_q, wdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          w0;
    logic        gd;
    logic        exp_d;
    logic [31:0] exp_rd;
    bus.i_req   = 1'b0;
    bus.i_addr  = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_wr    = 1'b0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    bus.d_size  = 2'b00;
    bus.d_sz_ex = 1'b0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_i_ack", 32'(bus.i_ack), 32'd0);
    check_eq("rst_d_ack", 32'(bus.d_ack), 32'd0);
    check_eq("rst_fault", 32'(bus.d_fault), 32'd0);
    check_eq("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
    check_eq("rst_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Fetch only.
    w0         = wr_cnt;
    bus.i_addr = 32'h0000_0008;
    bus.i_req  = 1'b1;
    @(negedge clk);
    check_eq("f_busy", 32'(bus.busy), 32'd1);
    check_eq("f_addr", bus.mem_addr, 32'h0000_0008);
    check_eq("f_size", 32'(bus.mem_size), 32'd2);
    check_eq("f_ack_early", 32'(bus.i_ack), 32'd0);
    wait_ack(n, gd);
    bus.i_req = 1'b0;
    check_eq("f_lat", 32'(n + 1), 32'd2);
    check_eq("f_is_i", 32'(gd), 32'd0);
    check_eq("f_rdata", bus.i_rdata, 32'h0050_0093);
    @(negedge clk);
    check_eq("f_ack_drop", 32'(bus.i_ack), 32'd0);
    check_eq("f_busy_idle", 32'(bus.busy), 32'd0);
    check_eq("f_no_wr", 32'(wr_cnt - w0), 32'd0);

    run_d("st40", 32'h0000_0040, 1'b1, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0);
    run_d("st10", 32'h0000_0010, 1'b1, 32'h1111_2222, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0);
    run_d("st1f", 32'h0000_001F, 1'b1, 32'h3333_4444, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
    run_d("st20", 32'h0000_0020, 1'b1, 32'h5555_6666, 2'b01, 1'b0, 1'b1, 1'b0, 32'h0);
    run_d("ld10", 32'h0000_0010, 1'b0, 32'h0, 2'b01, 1'b1, 1'b0, 1'b0, 32'h1000_0010);

    // Tie after reset: fetch first, then alternate.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.i_addr = 32'h0000_0004;
    bus.d_addr = 32'h0000_0080;
    bus.d_wr   = 1'b0;
    bus.i_req  = 1'b1;
    bus.d_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(n, gd);
      exp_d  = (k % 2 == 1);
      exp_rd = exp_d ? 32'h1000_0080 : 32'h1000_0004;
      check_eq($sformatf("tie%0d_who", k), 32'(gd), 32'(exp_d));
      check_eq($sformatf("tie%0d_gap", k), 32'(n), (k == 0) ? 32'd2 : 32'd3);
      check_eq($sformatf("tie%0d_rdata", k), exp_d ? bus.d_rdata : bus.i_rdata, exp_rd);
      check_eq($sformatf("tie%0d_both", k), 32'(bus.i_ack & bus.d_ack), 32'd0);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a store.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.d_addr  = 32'h0000_0044;
    bus.d_wdata = 32'h1234_5678;
    bus.d_size  = 2'b10;
    bus.d_wr    = 1'b1;
    bus.d_req   = 1'b1;
    @(negedge clk);
    check_eq("mr_pre_wr_en", 32'(bus.mem_wr_en), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("mr_wr_en_async", 32'(bus.mem_wr_en), 32'd0);
    check_eq("mr_busy_async", 32'(bus.busy), 32'd0);
    check_eq("mr_addr_async", bus.mem_addr, 32'h0);
    @(negedge clk);
    check_eq("mr_no_ack", 32'(bus.d_ack), 32'd0);
    rst = 1'b0;
    w0  = wr_cnt;
    wait_ack(n, gd);
    bus.d_req = 1'b0;
    check_eq("mr_lat", 32'(n), 32'd2);
    check_eq("mr_d_ack", 32'(gd), 32'd1);
    check_eq("mr_fault", 32'(bus.d_fault), 32'd0);
    @(negedge clk);
    check_eq("mr_wr_cnt", 32'(wr_cnt - w0), 32'd1);
    check_eq("mr_wr_addr", wr_addr_q, 32'h0000_0044);
    check_eq("mr_wr_data", wr_data_q, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule
